// File: rtl/aes_pkg.sv
// Shared constants for the AES substitution stages: FIPS-197 S-box tables and state geometry.
// AES_SBOX (forward table) exists only when AES_ISBOX_FWD_MODE_EN is defined.
package aes_pkg;

    localparam int AES_NO_ROWS = 4;
    localparam int AES_NO_COLS = 4;

    typedef logic [AES_NO_ROWS-1:0][AES_NO_COLS-1:0][7:0] aes_state_t;

    localparam logic [7:0] AES_INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

`ifdef AES_ISBOX_FWD_MODE_EN
    localparam logic [7:0] AES_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
`endif

endpackage

// File: rtl/aes_inv_sbox_lut.sv
// Single-byte combinational S-box lookup; inverse table by default.
// With AES_ISBOX_FWD_MODE_EN, fwd_mode=1 selects the forward table instead.
module aes_inv_sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] lut_in,
`ifdef AES_ISBOX_FWD_MODE_EN
    input  logic       fwd_mode,
`endif
    output logic [7:0] lut_out
);

    always_comb begin
        lut_out = AES_INV_SBOX[lut_in];
`ifdef AES_ISBOX_FWD_MODE_EN
        if (fwd_mode) begin
            lut_out = AES_SBOX[lut_in];
        end
`endif
    end

endmodule

// File: rtl/aes_isbox.sv
// InvSubBytes stage: per-element row/column-masked S-box lookup into a registered state matrix.
// Optional AES_ISBOX_FWD_MODE_EN adds fwd_mode to select the forward S-box.
module aes_isbox
    import aes_pkg::*;
#(
    parameter int NO_ROWS = AES_NO_ROWS,
    parameter int NO_COLS = AES_NO_COLS
) (
    input  logic                                 aes_clk,
    input  logic                                 resetn,
    input  logic                                 isbox_en,
`ifdef AES_ISBOX_FWD_MODE_EN
    input  logic                                 fwd_mode,
`endif
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] isbox_ip_char_matrix,
    input  logic [NO_ROWS-1:0]                   isbox_ip_char_row_mask,
    input  logic [NO_COLS-1:0]                   isbox_ip_char_col_mask,
    output logic                                 isbox_op_char_matrix_valid,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] isbox_op_char_matrix
);

    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] sub_byte;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] gated_byte;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_d, mat_q;
    logic                                 valid_d, valid_q;

    for (genvar r = 0; r < NO_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NO_COLS; c++) begin : g_col
            aes_inv_sbox_lut u_lut (
                .lut_in   (isbox_ip_char_matrix[r][c]),
`ifdef AES_ISBOX_FWD_MODE_EN
                .fwd_mode (fwd_mode),
`endif
                .lut_out  (sub_byte[r][c])
            );

            assign gated_byte[r][c] = (isbox_ip_char_row_mask[r] & isbox_ip_char_col_mask[c])
                                    ? sub_byte[r][c] : isbox_ip_char_matrix[r][c];
        end
    end

    // Output holds after enable drops so the controller can still read the result.
    always_comb begin
        mat_d   = mat_q;
        valid_d = isbox_en;
        if (isbox_en) begin
            mat_d = gated_byte;
        end
    end

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            mat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mat_q   <= mat_d;
            valid_q <= valid_d;
        end
    end

    assign isbox_op_char_matrix       = mat_q;
    assign isbox_op_char_matrix_valid = valid_q;

endmodule

// File: tb/tb_aes_isbox.sv
// Scoreboard bench for aes_isbox; S-box reference is derived from GF(2^8) arithmetic.
module tb_aes_isbox;
    import aes_pkg::*;

    logic       aes_clk = 1'b0;
    logic       resetn;
    logic       isbox_en;
    aes_state_t in_mat;
    logic [3:0] row_mask;
    logic [3:0] col_mask;
    logic       out_vld;
    aes_state_t out_mat;
`ifdef AES_ISBOX_FWD_MODE_EN
    logic       fwd_mode;
`endif

    typedef struct packed {
        aes_state_t mat;
        logic       vld;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] fwd_tb [256];
    logic [7:0] inv_tb [256];
    aes_state_t exp_mat;
    logic       exp_vld;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 aes_clk = ~aes_clk;

    aes_isbox dut (
        .aes_clk                    (aes_clk),
        .resetn                     (resetn),
        .isbox_en                   (isbox_en),
`ifdef AES_ISBOX_FWD_MODE_EN
        .fwd_mode                   (fwd_mode),
`endif
        .isbox_ip_char_matrix       (in_mat),
        .isbox_ip_char_row_mask     (row_mask),
        .isbox_ip_char_col_mask     (col_mask),
        .isbox_op_char_matrix_valid (out_vld),
        .isbox_op_char_matrix       (out_mat)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fwd_tb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tb[fwd_tb[x]] = 8'(x);
    endtask

    function automatic aes_state_t fill(input logic [7:0] b);
        aes_state_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[r][c] = b;
        return m;
    endfunction

    function automatic aes_state_t model(input aes_state_t m, input logic [3:0] rm,
                                         input logic [3:0] cm, input logic fm);
        aes_state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = (rm[r] && cm[c]) ? (fm ? fwd_tb[m[r][c]] : inv_tb[m[r][c]]) : m[r][c];
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input aes_state_t m, input logic [3:0] rm, input logic [3:0] cm,
                        input logic en, input logic fm);
        sb_t e;
        in_mat   = m;
        row_mask = rm;
        col_mask = cm;
        isbox_en = en;
`ifdef AES_ISBOX_FWD_MODE_EN
        fwd_mode = fm;
`endif
        if (en) exp_mat = model(m, rm, cm, fm);
        exp_vld = en;
        e.mat = exp_mat;
        e.vld = exp_vld;
        sb_q.push_back(e);
        @(posedge aes_clk);
        #1;
        e = sb_q.pop_front();
        check("matrix", out_mat, e.mat);
        check("valid", {127'b0, out_vld}, {127'b0, e.vld});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        aes_state_t m;
        aes_state_t f;
        resetn   = 1'b0;
        isbox_en = 1'b0;
        in_mat   = '0;
        row_mask = 4'h0;
        col_mask = 4'h0;
`ifdef AES_ISBOX_FWD_MODE_EN
        fwd_mode = 1'b0;
`endif
        exp_mat  = '0;
        exp_vld  = 1'b0;
        build_tables();
        #3;
        check("reset_matrix", out_mat, 128'h0);
        check("reset_valid", {127'b0, out_vld}, 128'h0);
        #9 resetn = 1'b1;
        @(posedge aes_clk);
        #1;

        step('0, 4'hf, 4'hf, 1'b0, 1'b0);
        step('0, 4'hf, 4'hf, 1'b0, 1'b0);

        step(fill(8'h00), 4'hf, 4'hf, 1'b1, 1'b0);
        check("full_zero_lit", out_mat, fill(8'h52));

        m = fill(8'h00);
        m[0][0] = 8'h63; m[0][1] = 8'h7c; m[1][0] = 8'hff; m[3][3] = 8'hed;
        step(m, 4'hf, 4'hf, 1'b1, 1'b0);
        check("lit_00", {120'b0, out_mat[0][0]}, 128'h00);
        check("lit_01", {120'b0, out_mat[0][1]}, 128'h01);
        check("lit_10", {120'b0, out_mat[1][0]}, 128'h7d);
        check("lit_33", {120'b0, out_mat[3][3]}, 128'h53);

        step(fill(8'h63), 4'h1, 4'h2, 1'b1, 1'b0);
        f = fill(8'h63);
        f[0][1] = 8'h00;
        check("partial_lit", out_mat, f);

        // handshake: drop enable, output holds, then re-raise with new data
        step(fill(8'h11), 4'hf, 4'hf, 1'b0, 1'b0);
        check("hold_lit", out_mat, f);
        step(fill(8'h11), 4'hf, 4'hf, 1'b0, 1'b0);
        step(fill(8'h52), 4'hf, 4'hf, 1'b1, 1'b0);
        check("reraise_lit", out_mat, fill(8'h48));

        m = {$urandom, $urandom, $urandom, $urandom};
        step(m, 4'h0, 4'h0, 1'b1, 1'b0);
        check("mask_zero_passthru", out_mat, m);

        for (int v = 0; v < 256; v++) begin
            step(fill(8'(v)), 4'hf, 4'hf, 1'b1, 1'b0);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) f[r][c] = fwd_tb[out_mat[r][c]];
            check("fwd_of_inv", f, fill(8'(v)));
        end

        for (int k = 0; k < 40; k++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            step(m, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
        end

        step(fill(8'h7c), 4'hf, 4'hf, 1'b1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("midop_reset_matrix", out_mat, 128'h0);
        check("midop_reset_valid", {127'b0, out_vld}, 128'h0);
        isbox_en = 1'b0;
        exp_mat  = '0;
        #2 resetn = 1'b1;
        @(posedge aes_clk);
        #1;
        step(fill(8'h7c), 4'hf, 4'hf, 1'b0, 1'b0);
        check("post_reset_lit", out_mat, 128'h0);

`ifdef AES_ISBOX_FWD_MODE_EN
        step(fill(8'h00), 4'hf, 4'hf, 1'b1, 1'b1);
        check("fwd_00_lit", out_mat, fill(8'h63));
        step(fill(8'h53), 4'h3, 4'h5, 1'b1, 1'b1);
        check("fwd_53_lit", {120'b0, out_mat[0][0]}, 128'hed);
        check("fwd_pass_lit", {120'b0, out_mat[3][3]}, 128'h53);
        for (int k = 0; k < 20; k++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            step(m, 4'($urandom), 4'($urandom), 1'b1, 1'($urandom));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_isbox.md
Name: aes_isbox

Overview:
- Inverse S-box substitution stage of the AES decryption core.
- Registers the byte-wise AES inverse S-box (InvSubBytes) of a 4x4 byte state matrix, with per-row and per-column masking.
- Reports completion through a valid flag that the round controller polls before advancing the round counter.

Parameters:
- NO_ROWS, 4, rows in the state matrix; also the row-mask width.
- NO_COLS, 4, columns in the state matrix; also the column-mask width.

Ports:
- aes_clk  input  1  clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- isbox_en  input  1  substitution request, level-sensitive.
- isbox_ip_char_matrix  input  8 x [NO_ROWS][NO_COLS]  input state bytes.
- isbox_ip_char_row_mask  input  NO_ROWS  bit i=1 enables row i.
- isbox_ip_char_col_mask  input  NO_COLS  bit j=1 enables column j.
- isbox_op_char_matrix_valid  output  1  output matrix valid.
- isbox_op_char_matrix  output  8 x [NO_ROWS][NO_COLS]  substituted state bytes, registered.

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is aes_clk.
  - While resetn=0, all isbox_op_char_matrix bytes=0x00 and isbox_op_char_matrix_valid=0.
  - Reset takes effect immediately, including mid-operation.
- Element function, per element (i,j):
  - If row_mask[i] & col_mask[j]: out[i][j] = InvSbox[in[i][j]], the standard FIPS-197 inverse S-box (256x8 ROM, pure combinational lookup).
  - Otherwise: out[i][j] = in[i][j], unchanged pass-through.
- Rising edge with isbox_en=1:
  - All output bytes load the element function of the current inputs and masks.
  - valid is set to 1.
  - Latency is 1 cycle from the first sampled isbox_en=1 to valid=1 with correct data.
- Held enable:
  - While isbox_en stays 1, the output re-evaluates every cycle, tracking input/mask changes with 1-cycle latency.
  - valid stays 1.
- Rising edge with isbox_en=0:
  - valid clears to 0.
  - The output matrix holds its last value, so the controller can read it after dropping enable.
- Handshake: the requester raises isbox_en, waits for valid=1, then lowers isbox_en. valid must fall the cycle after enable falls so the next request sees a fresh 0->1 transition.
- Masks all zero with isbox_en=1: the output equals the input after 1 cycle and valid=1.
- No internal state beyond the output register and the valid flip-flop.

Optional Feature:
- Macro: AES_ISBOX_FWD_MODE_EN.
- When defined:
  - Adds input port fwd_mode (1 bit).
  - fwd_mode=1 selects the forward FIPS-197 S-box instead of the inverse for masked elements.
  - fwd_mode=0 gives identical behaviour to the base design.
  - Latency and handshake are unchanged.
- When undefined: no fwd_mode port, no forward ROM, inverse only.

Decomposition:
- Package aes_pkg:
  - AES_INV_SBOX constant (256 x 8-bit), plus AES_SBOX when the feature macro is set.
  - State-matrix dimension constants.
  - Typedef aes_state_t for an 8-bit [4][4] matrix.
- Sub-module aes_inv_sbox_lut:
  - Single-byte combinational lookup from the package constant (optionally the forward table).
  - Instantiated NO_ROWS*NO_COLS times via generate.
- Top level holds only the mask gating and the registers.

Test Plan:
- Reset: assert resetn=0 mid-operation -> immediately valid=0 and all outputs 0x00. Release, isbox_en=0 -> outputs stay 0x00, valid=0.
- Full mask:
  - Setup: in all 0x00, masks 0xF, isbox_en=1.
  - After 1 edge: all outputs 0x52 and valid=1.
  - Then in[0][0]=0x63, in[0][1]=0x7C, in[1][0]=0xFF, in[3][3]=0xED -> next edge outputs 0x00, 0x01, 0x7D, 0x53.
- Partial mask:
  - Setup: row_mask=0x1, col_mask=0x2, all in=0x63, isbox_en=1.
  - Response: only out[0][1]=0x00; the other 15 bytes = 0x63.
- Handshake: drop isbox_en after valid=1 -> next edge valid=0, outputs unchanged. Re-raise -> valid=1 exactly 1 edge later.
- Exhaustive: sweep the input byte 0x00..0xFF in all elements with full mask -> every output matches the FIPS-197 inverse table, and forward S-box of output equals input.
- With AES_ISBOX_FWD_MODE_EN and fwd_mode=1: in=0x00 -> 0x63; in=0x53 -> 0xED. Unmasked elements pass through.
